// File: rtl/mdu_div_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mdu_div_ctrl_pkg
//   Shared definitions for the MDU divider sequencer:
//     - div_op_t   : operation encoding (DIV=0, DIVU=1, MOD=2, MODU=3)
//     - ROB_ID_W_DEF / rob_id_t : default ROB tag width and tag type
//     - op_is_signed / op_is_rem : operation decode helpers
// ---------------------------------------------------------------------------
package mdu_div_ctrl_pkg;

  localparam int ROB_ID_W_DEF = 6;

  typedef logic [ROB_ID_W_DEF-1:0] rob_id_t;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    MOD  = 2'd2,
    MODU = 2'd3
  } div_op_t;

  // Signed variants take absolute values before iterating and fix signs after.
  function automatic logic op_is_signed(input div_op_t op);
    return (op == DIV) || (op == MOD);
  endfunction

  // Remainder-returning variants.
  function automatic logic op_is_rem(input div_op_t op);
    return (op == MOD) || (op == MODU);
  endfunction

endpackage

// File: rtl/mdu_div_ctrl_div_step.sv
// ---------------------------------------------------------------------------
// mdu_div_ctrl_div_step
//   One combinational radix-2 restoring division step.
//   Ports:
//     i_rem     partial remainder (WIDTH)
//     i_quo     dividend/quotient shift register (WIDTH); MSB shifts into rem
//     i_divisor unsigned divisor magnitude (WIDTH)
//     o_rem     next partial remainder
//     o_quo     next quotient register (new quotient bit shifted in at LSB)
// ---------------------------------------------------------------------------
module mdu_div_ctrl_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  // The shifted remainder is kept WIDTH+1 bits wide: the remainder can have
  // its MSB set when the divisor magnitude exceeds 2^(WIDTH-1).
  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_t    = {i_rem, i_quo[WIDTH-1]};
    w_ge   = (w_t >= {1'b0, i_divisor});
    // Only used when t >= divisor, so the true difference fits in WIDTH bits.
    w_diff = w_t[WIDTH-1:0] - i_divisor;
    o_rem  = w_ge ? w_diff : w_t[WIDTH-1:0];
    o_quo  = {i_quo[WIDTH-2:0], w_ge};
  end

endmodule

// File: rtl/mdu_div_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_div_ctrl
//   Sequencer for the MDU iterative divider. Accepts one DIV/DIVU/MOD/MODU
//   request via valid_i/ready_o, runs WIDTH restoring iterations and returns
//   the quotient or remainder via valid_o/ready_i.
//   Ports:
//     clk, rst, flush       clock, sync active-high reset, pipeline flush
//     valid_i / ready_o     request handshake (ready_o = controller idle)
//     op_i                  div_op_t encoding
//     dividend_i, divisor_i operands
//     reg_id_i / reg_id_o   ROB tag in / tag of returned result
//     valid_o / ready_i     result handshake; result held until ready_i
//     data_o                quotient (DIV/DIVU) or remainder (MOD/MODU)
//     busy_o                controller not idle
// ---------------------------------------------------------------------------
module mdu_div_ctrl
  import mdu_div_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int ROB_ID_W = ROB_ID_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [1:0]          op_i,
  input  logic [WIDTH-1:0]    dividend_i,
  input  logic [WIDTH-1:0]    divisor_i,
  input  logic [ROB_ID_W-1:0] reg_id_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [WIDTH-1:0]    data_o,
  output logic [ROB_ID_W-1:0] reg_id_o,
  output logic                busy_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  div_op_t               r_op;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;      // raw divisor, replaced by |B| in PREP
  logic [WIDTH-1:0]      r_rem;
  logic [WIDTH-1:0]      r_quo;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_sq;
  logic                  r_sr;
  logic [WIDTH-1:0]      r_data;
  logic [ROB_ID_W-1:0]   r_tag;

  logic                  w_sa;
  logic                  w_sb;
  logic [WIDTH-1:0]      w_abs_a;
  logic [WIDTH-1:0]      w_abs_b;
  logic [WIDTH-1:0]      w_rem_step;
  logic [WIDTH-1:0]      w_quo_step;
  logic [WIDTH-1:0]      w_q_fix;
  logic [WIDTH-1:0]      w_r_fix;
  logic                  w_kill;

  assign w_kill = rst | flush;

  // Operand sign handling for PREP; unsigned ops never negate.
  always_comb begin
    w_sa    = op_is_signed(r_op) & r_a[WIDTH-1];
    w_sb    = op_is_signed(r_op) & r_b[WIDTH-1];
    w_abs_a = w_sa ? (-r_a) : r_a;
    w_abs_b = w_sb ? (-r_b) : r_b;
    // Two's-complement negation wraps, so INT_MIN / -1 yields INT_MIN.
    w_q_fix = r_sq ? (-r_quo) : r_quo;
    w_r_fix = r_sr ? (-r_rem) : r_rem;
  end

  mdu_div_ctrl_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_b),
    .o_rem     (w_rem_step),
    .o_quo     (w_quo_step)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    busy_o       = 1'b1;
    case (r_state)
      IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
        if (valid_i) w_state_next = PREP;
      end
      PREP: w_state_next = (r_b == '0) ? DONE : ITER;
      ITER: if (r_cnt == CNT_LAST) w_state_next = FIX;
      FIX:  w_state_next = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_op   <= DIV;
      r_a    <= '0;
      r_b    <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_sq   <= 1'b0;
      r_sr   <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_op  <= div_op_t'(op_i);
            r_a   <= dividend_i;
            r_b   <= divisor_i;
            r_tag <= reg_id_i;
          end
        end
        PREP: begin
          r_quo <= w_abs_a;
          r_b   <= w_abs_b;
          r_sq  <= w_sa ^ w_sb;
          r_sr  <= w_sa;
          r_rem <= '0;
          r_cnt <= '0;
          // Divide-by-zero skips iteration: all-ones quotient, raw dividend remainder.
          if (r_b == '0) begin
            r_data <= op_is_rem(r_op) ? r_a : '1;
          end
        end
        ITER: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_data <= op_is_rem(r_op) ? w_r_fix : w_q_fix;
        end
        default: ;
      endcase
    end
  end

  assign data_o   = r_data;
  assign reg_id_o = r_tag;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_div_ctrl
//   Directed self-checking bench for mdu_div_ctrl (WIDTH=32, ROB_ID_W=6).
// ---------------------------------------------------------------------------
module tb_mdu_div_ctrl;

  localparam int W  = 32;
  localparam int RW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          valid_i;
  logic          ready_o;
  logic [1:0]    op_i;
  logic [W-1:0]  dividend_i;
  logic [W-1:0]  divisor_i;
  logic [RW-1:0] reg_id_i;
  logic          valid_o;
  logic          ready_i;
  logic [W-1:0]  data_o;
  logic [RW-1:0] reg_id_o;
  logic          busy_o;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  mdu_div_ctrl #(.WIDTH(W), .ROB_ID_W(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .reg_id_i   (reg_id_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_o     (data_o),
    .reg_id_o   (reg_id_o),
    .busy_o     (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one request, measure latency to valid_o, check result and tag,
  // optionally stall ready_i for 'hold' cycles in DONE, then check return to idle.
  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RW-1:0] tag,
                       input int exp_lat, input logic [W-1:0] exp_data, input int hold);
    int   cyc;
    logic rdy_seen;
    @(negedge clk);
    chk({name, " ready_before"}, ready_o, 1'b1);
    ready_i    = (hold == 0);
    valid_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    reg_id_i   = tag;
    @(posedge clk);            // accept edge = cycle 0
    #1;
    valid_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    reg_id_i   = '0;
    cyc        = 1;
    rdy_seen   = 1'b0;
    while (!valid_o && cyc < 100) begin
      if (ready_o) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({name, " ready_low_while_busy"}, {rdy_seen, ready_o}, 2'b00);
    chk({name, " data"}, data_o, exp_data);
    chk({name, " tag"}, reg_id_o, tag);
    $display("op=%0d a=0x%08h b=0x%08h tag=%0d -> data=0x%08h tag=%0d lat=%0d",
             op, a, b, tag, data_o, reg_id_o, cyc);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({name, " hold_valid"}, valid_o, 1'b1);
      chk({name, " hold_data"}, data_o, exp_data);
      chk({name, " hold_tag"}, reg_id_o, tag);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    chk({name, " after_valid"}, valid_o, 1'b0);
    chk({name, " after_ready"}, ready_o, 1'b1);
  endtask

  initial begin
    int pulses;
    rst        = 1'b1;
    flush      = 1'b0;
    valid_i    = 1'b0;
    op_i       = 2'd0;
    dividend_i = '0;
    divisor_i  = '0;
    reg_id_i   = '0;
    ready_i    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst ready_o",  ready_o,  1'b1);
    chk("rst valid_o",  valid_o,  1'b0);
    chk("rst busy_o",   busy_o,   1'b0);
    chk("rst data_o",   data_o,   32'h0);
    chk("rst reg_id_o", reg_id_o, 6'h0);

    // Basic and signed cases.
    do_op("div100_7",   2'd0, 32'd100,        32'd7,          6'd5,  35, 32'd14,        0);
    do_op("mod_m7_2",   2'd2, 32'hFFFF_FFF9,  32'd2,          6'd1,  35, 32'hFFFF_FFFF, 0);
    do_op("modu_m7_2",  2'd3, 32'hFFFF_FFF9,  32'd2,          6'd2,  35, 32'h1,         0);
    do_op("div_m100_7", 2'd0, 32'hFFFF_FF9C,  32'd7,          6'd3,  35, 32'hFFFF_FFF2, 0);
    do_op("mod_m100_7", 2'd2, 32'hFFFF_FF9C,  32'd7,          6'd4,  35, 32'hFFFF_FFFE, 0);
    // Boundaries.
    do_op("divu_max_1", 2'd1, 32'hFFFF_FFFF,  32'd1,          6'd6,  35, 32'hFFFF_FFFF, 0);
    do_op("div_min_m1", 2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  6'd7,  35, 32'h8000_0000, 0);
    do_op("mod_min_m1", 2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  6'd8,  35, 32'h0,         0);
    do_op("divu_big",   2'd1, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  6'd9,  35, 32'h0,         0);
    do_op("modu_big",   2'd3, 32'hFFFF_FFFE,  32'h8000_0001,  6'd10, 35, 32'h7FFF_FFFD, 0);
    do_op("div_123_0",  2'd0, 32'd123,        32'd0,          6'd11, 2,  32'hFFFF_FFFF, 0);
    do_op("mod_123_0",  2'd2, 32'd123,        32'd0,          6'd12, 2,  32'd123,       0);

    // Flush in the middle of iteration.
    @(negedge clk);
    valid_i    = 1'b1;
    op_i       = 2'd0;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    reg_id_i   = 6'd20;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (11) @(posedge clk);   // now in ITER step 10
    @(negedge clk);
    chk("flush busy_before", busy_o, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush ready_o",  ready_o,  1'b1);
    chk("flush busy_o",   busy_o,   1'b0);
    chk("flush data_o",   data_o,   32'h0);
    chk("flush reg_id_o", reg_id_o, 6'h0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (valid_o) pulses++;
    end
    chk("flush no_valid_pulse", 64'(pulses), 64'd0);
    $display("flush during ITER -> valid pulses after flush=%0d", pulses);
    do_op("div9_3_post_flush", 2'd0, 32'd9, 32'd3, 6'd21, 35, 32'd3, 0);

    // Result held while downstream stalls.
    do_op("divu_hold", 2'd1, 32'd1000, 32'd10, 6'd63, 35, 32'd100, 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
